frost32_irq_ctrl: RTL and testbench

Parametrised interrupt controller that drives the `interrupt` input of `Frost32Cpu`. It aggregates `NUM_CHAN` interrupt sources, each configurable as edge or level, with per-channel enable and pending latches. It dispatches one fixed-length interrupt pulse at a time, lowest channel index first, and never starts a pulse while main memory is stalling the CPU. It sits between peripheral or bench stimulus sources and the CPU, beside `MainMem`.

---
 rtl/frost32_irq_ctrl_if.sv | 27 ++
 rtl/frost32_irq_ctrl.sv | 123 ++++++++++++
 tb/tb_frost32_irq_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/frost32_irq_ctrl_if.sv
// rtl/frost32_irq_ctrl_if.sv - source/CPU-side signal bundle for frost32_irq_ctrl
// master: interrupt sources and stall/clear drivers; slave: the controller itself.
interface frost32_irq_ctrl_if #(
  parameter int NUM_CHAN = 4,
  parameter int IDW      = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
);
  logic [NUM_CHAN-1:0] irq_src;
  logic [NUM_CHAN-1:0] edge_mode;
  logic [NUM_CHAN-1:0] enable;
  logic                wait_for_mem;
  logic                clr_valid;
  logic [IDW-1:0]      clr_chan;
  logic                interrupt;
  logic [IDW-1:0]      irq_id;
  logic [NUM_CHAN-1:0] pending;
  logic [15:0]         dispatch_count;

  modport master (
    output irq_src, edge_mode, enable, wait_for_mem, clr_valid, clr_chan,
    input  interrupt, irq_id, pending, dispatch_count
  );

  modport slave (
    input  irq_src, edge_mode, enable, wait_for_mem, clr_valid, clr_chan,
    output interrupt, irq_id, pending, dispatch_count
  );
endinterface

// File: rtl/frost32_irq_ctrl.sv
// rtl/frost32_irq_ctrl.sv - edge/level interrupt aggregator driving Frost32Cpu.interrupt
// Optional dispatch statistics counter: FROST32_IRQ_CTRL_STATS_EN.
module frost32_irq_ctrl #(
  parameter int NUM_CHAN  = 4,
  parameter int PULSE_LEN = 3,
  parameter int GAP_LEN   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  frost32_irq_ctrl_if.slave  bus
);
  localparam int IDW    = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam int MAXLEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CW     = (MAXLEN > 0) ? $clog2(MAXLEN + 1) : 1;

  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] GAP_LOAD   = (GAP_LEN > 0) ? CW'(GAP_LEN - 1) : '0;
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]          r_state;
  logic [CW-1:0]       r_cnt;
  logic [IDW-1:0]      r_irq_id;
  logic [NUM_CHAN-1:0] r_pending;
  logic [NUM_CHAN-1:0] r_prev_src;

  logic [NUM_CHAN-1:0] w_edge;
  logic [NUM_CHAN-1:0] w_cand;
  logic [NUM_CHAN-1:0] w_sel_onehot;
  logic [NUM_CHAN-1:0] w_clr_hit;
  logic [NUM_CHAN-1:0] w_pending_nxt;
  logic [IDW-1:0]      w_sel_id;
  logic                w_decide;
  logic                w_start;

  assign w_edge       = bus.irq_src & ~r_prev_src;
  assign w_cand       = r_pending & bus.enable;
  assign w_sel_onehot = w_cand & (~w_cand + NUM_CHAN'(1));

  always_comb begin
    w_sel_id = '0;
    for (int i = NUM_CHAN - 1; i >= 0; i--) begin
      if (w_cand[i]) w_sel_id = IDW'(i);
    end
  end

  // The final gap cycle doubles as the idle decision point, so back-to-back
  // dispatches are exactly PULSE_LEN + GAP_LEN cycles apart.
  assign w_decide = (r_state == S_IDLE) || ((r_state == S_GAP) && (r_cnt == '0));
  assign w_start  = w_decide && (|w_cand) && !bus.wait_for_mem;

  always_comb begin
    w_clr_hit     = '0;
    w_pending_nxt = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      w_clr_hit[i] = bus.clr_valid && (bus.clr_chan == IDW'(i));
      if (bus.edge_mode[i])
        w_pending_nxt[i] = w_edge[i] |
                           (r_pending[i] & ~w_clr_hit[i] & ~(w_start & w_sel_onehot[i]));
      else
        w_pending_nxt[i] = bus.irq_src[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_irq_id   <= '0;
      r_pending  <= '0;
      r_prev_src <= '0;
    end else begin
      r_prev_src <= bus.irq_src;
      r_pending  <= w_pending_nxt;
      case (r_state)
        S_PULSE: begin
          if (r_cnt == '0) begin
            if (GAP_LEN > 0) begin
              r_state <= S_GAP;
              r_cnt   <= GAP_LOAD;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_GAP: begin
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_ONE;
          else             r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_start) begin
        r_state  <= S_PULSE;
        r_cnt    <= PULSE_LOAD;
        r_irq_id <= w_sel_id;
      end
    end
  end

  assign bus.interrupt = (r_state == S_PULSE);
  assign bus.irq_id    = r_irq_id;
  assign bus.pending   = r_pending;

`ifdef FROST32_IRQ_CTRL_STATS_EN
  logic [15:0] r_dispatch_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_dispatch_count <= '0;
    else if (w_start && (r_dispatch_count != 16'hFFFF))
      r_dispatch_count <= r_dispatch_count + 16'd1;
  end

  assign bus.dispatch_count = r_dispatch_count;
`else
  assign bus.dispatch_count = 16'h0000;
`endif
endmodule

// File: tb/tb_frost32_irq_ctrl.sv
// tb/tb_frost32_irq_ctrl.sv - scoreboard bench for frost32_irq_ctrl
// Reference model tracks pending sets and a "busy until" cycle stamp per dispatch.
module tb_frost32_irq_ctrl;
  localparam int NC  = 4;
  localparam int PL  = 3;
  localparam int GL  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  frost32_irq_ctrl_if #(.NUM_CHAN(NC)) bus ();

  frost32_irq_ctrl #(.NUM_CHAN(NC), .PULSE_LEN(PL), .GAP_LEN(GL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct { int cyc; int id; } disp_t;
  disp_t exp_q[$];

  logic [NC-1:0] m_pend;
  logic [NC-1:0] m_prev;
  int            m_free_at;
  int            m_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a dispatch may start once the previous one's pulse+gap window has elapsed.
  always @(posedge clk) begin : model
    logic [NC-1:0] edg, cand, nxt;
    int sel, k;
    k   = cyc + 1;
    cyc <= k;
    if (!rst_n) begin
      m_pend    <= '0;
      m_prev    <= '0;
      m_free_at <= 0;
      m_count   <= 0;
      exp_q.delete();
    end else begin
      edg  = bus.irq_src & ~m_prev;
      cand = m_pend & bus.enable;
      sel  = -1;
      if (k >= m_free_at && cand != '0 && !bus.wait_for_mem) begin
        for (int i = NC - 1; i >= 0; i--) if (cand[i]) sel = i;
        exp_q.push_back('{k, sel});
        m_free_at <= k + PL + ((GL == 0) ? 1 : GL);
        m_count   <= (m_count == 65535) ? m_count : m_count + 1;
      end
      for (int i = 0; i < NC; i++) begin
        if (bus.edge_mode[i])
          nxt[i] = edg[i] | (m_pend[i] & !(bus.clr_valid && int'(bus.clr_chan) == i) & (sel != i));
        else
          nxt[i] = bus.irq_src[i];
      end
      m_pend <= nxt;
      m_prev <= bus.irq_src;
    end
  end

  int   hi_len   = 0;
  logic prev_int = 1'b0;

  always @(negedge clk) begin : monitor
    disp_t e;
    if (!rst_n) begin
      hi_len   = 0;
      prev_int = 1'b0;
    end else begin
      if (bus.interrupt && !prev_int) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_dispatch: actual irq_id=%0d expected no dispatch (cycle %0d)",
                   bus.irq_id, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("dispatch_cycle", cyc, e.cyc);
          chk("dispatch_id", 32'(bus.irq_id), e.id);
        end
      end
      if (bus.interrupt) hi_len++;
      else if (prev_int) begin
        chk("pulse_len", hi_len, PL);
        hi_len = 0;
      end
      prev_int = bus.interrupt;
      chk("pending", 32'(bus.pending), 32'(m_pend));
`ifdef FROST32_IRQ_CTRL_STATS_EN
      chk("dispatch_count", 32'(bus.dispatch_count), m_count);
`else
      chk("dispatch_count", 32'(bus.dispatch_count), 0);
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit seen;
    bus.irq_src      = '0;
    bus.edge_mode    = '1;
    bus.enable       = '1;
    bus.wait_for_mem = 1'b0;
    bus.clr_valid    = 1'b0;
    bus.clr_chan     = '0;
    step(3);
    chk("rst_interrupt", 32'(bus.interrupt), 0);
    chk("rst_irq_id", 32'(bus.irq_id), 0);
    chk("rst_pending", 32'(bus.pending), 0);
    chk("rst_dispatch_count", 32'(bus.dispatch_count), 0);
    rst_n = 1'b1;
    step(8);

    // single edge on ch2
    bus.irq_src = 4'b0100; step(1);
    bus.irq_src = 4'b0000; step(20);

    // ch3 and ch1 together: ch1 first, ch3 one pulse+gap later
    bus.irq_src = 4'b1010; step(1);
    bus.irq_src = 4'b0000; step(35);

    // stall holds ch0 back
    bus.wait_for_mem = 1'b1;
    bus.irq_src = 4'b0001; step(1);
    bus.irq_src = 4'b0000; step(20);
    bus.wait_for_mem = 1'b0; step(20);

    // level ch1 held, with a clear mid-run
    bus.edge_mode = 4'b1101;
    bus.irq_src   = 4'b0010;
    step(12);
    bus.clr_valid = 1'b1; bus.clr_chan = 2'd1; step(1);
    bus.clr_valid = 1'b0; step(17);
    bus.irq_src   = 4'b0000; step(20);
    bus.edge_mode = 4'b1111;

    // clear and rising edge on ch0 in the same cycle: set wins
    bus.enable  = 4'b1110;
    bus.irq_src = 4'b0001; step(1);
    bus.irq_src = 4'b0000; step(2);
    bus.clr_valid = 1'b1; bus.clr_chan = 2'd0; step(1);
    bus.clr_valid = 1'b0; step(2);
    bus.irq_src = 4'b0001; bus.clr_valid = 1'b1; bus.clr_chan = 2'd0; step(1);
    bus.irq_src = 4'b0000; bus.clr_valid = 1'b0;
    chk("clr_vs_set", 32'(bus.pending[0]), 1);
    bus.enable = 4'b1111; step(20);

    // randomized traffic
    for (int t = 0; t < 800; t++) begin
      if ($urandom_range(0, 3) == 0) bus.irq_src = NC'($urandom);
      if ($urandom_range(0, 49) == 0) bus.edge_mode = NC'($urandom);
      if ($urandom_range(0, 19) == 0) bus.enable = NC'($urandom);
      bus.wait_for_mem = ($urandom_range(0, 9) < 3);
      bus.clr_valid    = ($urandom_range(0, 4) == 0);
      bus.clr_chan     = 2'($urandom_range(0, NC - 1));
      step(1);
    end
    bus.irq_src = '0; bus.edge_mode = '1; bus.enable = '1;
    bus.wait_for_mem = 1'b0; bus.clr_valid = 1'b0;
    step(60);

    // reset during the second cycle of a pulse
    bus.irq_src = 4'b0100; step(1);
    bus.irq_src = 4'b0000;
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      step(1);
      if (bus.interrupt) seen = 1'b1;
    end
    chk("reset_wait_pulse", 32'(seen), 1);
    bus.irq_src = 4'b1001;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_interrupt", 32'(bus.interrupt), 0);
    chk("rst_mid_pending", 32'(bus.pending), 0);
    chk("rst_mid_dispatch_count", 32'(bus.dispatch_count), 0);
    step(2);
    rst_n = 1'b1;

    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 3) == 0) bus.irq_src = NC'($urandom);
      bus.wait_for_mem = ($urandom_range(0, 9) < 2);
      bus.clr_valid    = ($urandom_range(0, 5) == 0);
      bus.clr_chan     = 2'($urandom_range(0, NC - 1));
      step(1);
    end
    bus.irq_src = '0; bus.wait_for_mem = 1'b0; bus.clr_valid = 1'b0;
    step(80);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
